regfile_cmd_master: RTL and testbench

Initiator for the control/status register-file port: wren, byte-enable, address, write data, and a combinational read-data return. It accepts write, read and poll commands on a valid/ready stream and sequences the matching register-port accesses. Each command returns exactly one response on a valid/ready stream. It sits between a host-side command source (HPS bridge adapter or test sequencer) and the register file.

---
 rtl/regfile_cmd_pkg.sv | 30 +++
 rtl/regfile_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_regfile_cmd_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_cmd_pkg.sv
// Shared types for the register-file command master: op codes, response
// status codes, FSM states and the field widths they occupy.
package regfile_cmd_pkg;

    localparam int unsigned OP_W     = 2;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_BADOP   = 2'b10
    } status_t;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CHK  = 3'd3,
        S_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_cmd_master.sv
// Register-file command master: accepts write/read/poll commands on a
// valid/ready stream, sequences the register-port access(es) and returns one
// response per command on a valid/ready stream.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cmd_*               command stream (op, addr, be, data/compare, mask, tmo)
//   rsp_*               response stream (sample data, status)
//   reg_addr_o/data_o/be_o/wren_o, reg_data_i
//                       register-file port, combinational read return
module regfile_cmd_master
    import regfile_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = DATA_W / 8,
    parameter int unsigned RD_LAT = 0,
    parameter int unsigned TMO_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [OP_W-1:0]     cmd_op_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [BE_W-1:0]     cmd_be_i,
    input  logic [DATA_W-1:0]   cmd_data_i,
    input  logic [DATA_W-1:0]   cmd_mask_i,
    input  logic [TMO_W-1:0]    cmd_tmo_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic [STATUS_W-1:0] rsp_status_o,
    output logic [ADDR_W-1:0]   reg_addr_o,
    output logic [DATA_W-1:0]   reg_data_o,
    output logic [BE_W-1:0]     reg_be_o,
    output logic                reg_wren_o,
    input  logic [DATA_W-1:0]   reg_data_i
);

    localparam int unsigned LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    state_t              state_q,      state_d;
    op_t                 op_q,         op_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [BE_W-1:0]     be_q,         be_d;
    logic [DATA_W-1:0]   data_q,       data_d;
    logic [DATA_W-1:0]   mask_q,       mask_d;
    logic [TMO_W-1:0]    tmo_q,        tmo_d;
    logic [LAT_W-1:0]    lat_cnt_q,    lat_cnt_d;
    logic [TMO_W-1:0]    attempt_q,    attempt_d;
    logic [DATA_W-1:0]   sample_q,     sample_d;
    logic                cmd_ready_q,  cmd_ready_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    status_t             rsp_status_q, rsp_status_d;
    logic                reg_wren_q,   reg_wren_d;

    logic [TMO_W-1:0]    attempt_inc;
    logic [TMO_W-1:0]    tmo_lim;
    logic                poll_hit;

    // Next-state and next-output computation; every output is a flop fed from here.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        be_d         = be_q;
        data_d       = data_q;
        mask_d       = mask_q;
        tmo_d        = tmo_q;
        lat_cnt_d    = lat_cnt_q;
        attempt_d    = attempt_q;
        sample_d     = sample_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        reg_wren_d   = 1'b0;

        attempt_inc = attempt_q + TMO_W'(1);
        // A zero limit still performs one attempt.
        tmo_lim     = (tmo_q == '0) ? TMO_W'(1) : tmo_q;
        poll_hit    = ((sample_q ^ data_q) & mask_q) == '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d      = op_t'(cmd_op_i);
                    addr_d    = cmd_addr_i;
                    be_d      = cmd_be_i;
                    data_d    = cmd_data_i;
                    mask_d    = cmd_mask_i;
                    tmo_d     = cmd_tmo_i;
                    lat_cnt_d = '0;
                    attempt_d = '0;
                    unique case (op_t'(cmd_op_i))
                        OP_WR: begin
                            state_d    = S_WR;
                            reg_wren_d = |cmd_be_i;
                        end
                        OP_RD, OP_POLL: state_d = S_RD;
                        default: begin
                            state_d      = S_RESP;
                            rsp_status_d = ST_BADOP;
                            rsp_data_d   = '0;
                        end
                    endcase
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                rsp_status_d = ST_OK;
                rsp_data_d   = '0;
            end
            S_RD: begin
                // Address has been held RD_LAT extra cycles once lat_cnt reaches RD_LAT.
                if (lat_cnt_q == LAT_W'(RD_LAT)) begin
                    sample_d = reg_data_i;
                    if (op_q == OP_RD) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_OK;
                        rsp_data_d   = reg_data_i;
                    end else begin
                        state_d = S_CHK;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_CHK: begin
                attempt_d = attempt_inc;
                if (poll_hit) begin
                    state_d      = S_RESP;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = sample_q;
                end else if (attempt_inc == tmo_lim) begin
                    state_d      = S_RESP;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_data_d   = sample_q;
                end else begin
                    state_d   = S_RD;
                    lat_cnt_d = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_WR;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            tmo_q        <= '0;
            lat_cnt_q    <= '0;
            attempt_q    <= '0;
            sample_q     <= '0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            reg_wren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            tmo_q        <= tmo_d;
            lat_cnt_q    <= lat_cnt_d;
            attempt_q    <= attempt_d;
            sample_q     <= sample_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            reg_wren_q   <= reg_wren_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign reg_addr_o   = addr_q;
    assign reg_data_o   = data_q;
    assign reg_be_o     = be_q;
    assign reg_wren_o   = reg_wren_q;

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Self-checking bench for regfile_cmd_master: a small behavioural register
// file answers the register port, expected responses go into a scoreboard
// queue on command accept and are compared when the response appears.
module tb_regfile_cmd_master;
    import regfile_cmd_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [6:0]  cmd_addr_i;
    logic [1:0]  cmd_be_i;
    logic [15:0] cmd_data_i;
    logic [15:0] cmd_mask_i;
    logic [15:0] cmd_tmo_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic [6:0]  reg_addr_o;
    logic [15:0] reg_data_o;
    logic [1:0]  reg_be_o;
    logic        reg_wren_o;
    logic [15:0] reg_data_i;

    regfile_cmd_master dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_be_i     (cmd_be_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_mask_i   (cmd_mask_i),
        .cmd_tmo_i    (cmd_tmo_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .reg_addr_o   (reg_addr_o),
        .reg_data_o   (reg_data_o),
        .reg_be_o     (reg_be_o),
        .reg_wren_o   (reg_wren_o),
        .reg_data_i   (reg_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural register file; 0x41 is a status register owned by the bench.
    logic [15:0] mem [128];
    logic [15:0] status_reg;

    always @(posedge clk_i) begin
        if (reg_wren_o) begin
            for (int b = 0; b < 2; b++) begin
                if (reg_be_o[b]) mem[reg_addr_o][8*b +: 8] <= reg_data_o[8*b +: 8];
            end
        end
    end

    assign reg_data_i = (reg_addr_o == 7'h41) ? status_reg : mem[reg_addr_o];

    typedef struct {
        logic [1:0]  st;
        logic [15:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int wren_cnt = 0;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Response and write-strobe monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (reg_wren_o) begin
            wren_cnt++;
            wr_addr = reg_addr_o;
            wr_data = reg_data_o;
            wr_be   = reg_be_o;
        end
        if (!rst_i && rsp_valid_o) begin
            if (!prev_valid) check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                if (!prev_valid) check("rsp_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                check("rsp_data", 32'(rsp_data_o), 32'(exp_q[0].data));
                check("rsp_status", 32'(rsp_status_o), 32'(exp_q[0].st));
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    rsp_cnt++;
                end
            end
        end
        prev_valid = rsp_valid_o && !rst_i;
    end

    task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [1:0] be,
                        input logic [15:0] data, input logic [15:0] mask, input logic [15:0] tmo,
                        input bit push, input logic [1:0] est, input logic [15:0] edata,
                        input int elat);
        bit ok = 1'b0;
        @(posedge clk_i); #1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_be_i    = be;
        cmd_data_i  = data;
        cmd_mask_i  = mask;
        cmd_tmo_i   = tmo;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                ok = 1'b1;
                if (push) exp_q.push_back('{est, edata, elat, cyc});
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        bit seen;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = '0;
        cmd_addr_i  = '0;
        cmd_be_i    = '0;
        cmd_data_i  = '0;
        cmd_mask_i  = '0;
        cmd_tmo_i   = '0;
        rsp_ready_i = 1'b1;
        status_reg  = 16'h0000;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_reg_wren", 32'(reg_wren_o), 32'd0);
        check("rst_reg_addr", 32'(reg_addr_o), 32'd0);
        check("rst_rsp_data", 32'(rsp_data_o), 32'd0);

        // Full write, then read back.
        w0 = wren_cnt;
        send(2'b00, 7'h05, 2'b11, 16'hA55A, 16'h0, 16'd0, 1, ST_OK, 16'h0000, 2);
        wait_idle();
        check("wr1_pulses", 32'(wren_cnt - w0), 32'd1);
        check("wr1_addr", 32'(wr_addr), 32'h05);
        check("wr1_data", 32'(wr_data), 32'hA55A);
        check("wr1_be", 32'(wr_be), 32'h3);
        send(2'b01, 7'h05, 2'b00, 16'h0, 16'h0, 16'd0, 1, ST_OK, 16'hA55A, 2);
        wait_idle();

        // Low-byte write, then an all-disabled write that must not strobe.
        w0 = wren_cnt;
        send(2'b00, 7'h05, 2'b01, 16'h1234, 16'h0, 16'd0, 1, ST_OK, 16'h0000, 2);
        send(2'b00, 7'h05, 2'b00, 16'hFFFF, 16'h0, 16'd0, 1, ST_OK, 16'h0000, 2);
        wait_idle();
        check("wr2_pulses", 32'(wren_cnt - w0), 32'd1);
        check("wr2_be", 32'(wr_be), 32'h1);
        send(2'b01, 7'h05, 2'b00, 16'h0, 16'h0, 16'd0, 1, ST_OK, 16'hA534, 2);
        wait_idle();

        // Poll that succeeds on the third sample: 3 * 2 + 1 cycles.
        status_reg = 16'h0000;
        send(2'b10, 7'h41, 2'b00, 16'h0001, 16'h0001, 16'd10, 1, ST_OK, 16'h0001, 7);
        repeat (3) @(posedge clk_i);
        #1 status_reg = 16'h0001;
        wait_idle();

        // Poll timeouts: 4 attempts, and a zero limit meaning one attempt.
        send(2'b10, 7'h41, 2'b00, 16'h8000, 16'h8000, 16'd4, 1, ST_TIMEOUT, 16'h0001, 9);
        wait_idle();
        send(2'b10, 7'h41, 2'b00, 16'h8000, 16'h8000, 16'd0, 1, ST_TIMEOUT, 16'h0001, 3);
        wait_idle();

        // Reserved op.
        w0 = wren_cnt;
        send(2'b11, 7'h05, 2'b11, 16'hBEEF, 16'h0, 16'd0, 1, ST_BADOP, 16'h0000, 1);
        wait_idle();
        check("badop_pulses", 32'(wren_cnt - w0), 32'd0);

        // Response back-pressure with a stray command during the stall.
        @(posedge clk_i); #1 rsp_ready_i = 1'b0;
        send(2'b01, 7'h05, 2'b00, 16'h0, 16'h0, 16'd0, 1, ST_OK, 16'hA534, 2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            cmd_valid_i = (i == 2);
            cmd_op_i    = 2'b00;
            cmd_addr_i  = 7'h05;
            cmd_be_i    = 2'b11;
            cmd_data_i  = 16'hDEAD;
            @(negedge clk_i);
            check("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
        end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        wait_idle();
        check("stall_pulses", 32'(wren_cnt - w0), 32'd0);
        send(2'b01, 7'h05, 2'b00, 16'h0, 16'h0, 16'd0, 1, ST_OK, 16'hA534, 2);
        wait_idle();

        // Reset during the second poll attempt drops the command silently.
        r0 = rsp_cnt;
        send(2'b10, 7'h41, 2'b00, 16'h8000, 16'h8000, 16'd10, 0, ST_OK, 16'h0000, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_reg_wren", 32'(reg_wren_o), 32'd0);
        check("mid_rst_reg_addr", 32'(reg_addr_o), 32'd0);
        repeat (40) @(negedge clk_i);
        check("mid_rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        send(2'b01, 7'h05, 2'b00, 16'h0, 16'h0, 16'd0, 1, ST_OK, 16'hA534, 2);
        wait_idle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
